i2s_tx_param: RTL and testbench
===============================

I2S_TX_PARAM -- requirements
Module: i2s_tx_param

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16: bits per channel sample, 8..32.
REQ-002 SHALL have parameter SLOT_W, default 16: BCLK periods per channel slot, SAMPLE_W..32.
REQ-003 SHALL have parameter BCLK_DIV, default 64: clk cycles per BCLK period, even, >=4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: stereo sample entries, power of two, >=2.
REQ-005 SHALL have port clk, input, 1: single system clock; all logic runs on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-007 SHALL have port enable, input, 1: serial output runs while high.
REQ-008 SHALL have port mode, input, 1: 0 = Philips I2S (one-BCLK data delay), 1 = left-justified.
REQ-009 SHALL have port sample_l, input, SAMPLE_W: left sample, two's complement.
REQ-010 SHALL have port sample_r, input, SAMPLE_W: right sample, two's complement.
REQ-011 SHALL have port sample_valid, input, 1: producer offers a {l,r} pair.
REQ-012 SHALL have port sample_ready, output, 1: FIFO not full.
REQ-013 SHALL have port bclk, output, 1: serial bit clock.
REQ-014 SHALL have port lrclk, output, 1: word select, 0 = left, 1 = right.
REQ-015 SHALL have port sdata, output, 1: serial data, MSB first.
REQ-016 SHALL have port underrun, output, 1: one-clk pulse when a frame starts with the FIFO empty.
REQ-017 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1: current occupancy.

Function
REQ-018 SHALL accept a pair on a clk edge iff sample_valid && sample_ready; sample_ready = (fifo_level < FIFO_DEPTH), combinational from registered level.
REQ-019 SHALL run a divider div_cnt 0..BCLK_DIV-1 while enable; bclk registered = 1 when div_cnt >= BCLK_DIV/2, else 0.
REQ-020 SHALL define a falling-edge event at div_cnt wrap to 0; at each event bit_cnt advances 0..2*SLOT_W-1, wrapping.
REQ-021 SHALL drive lrclk = (bit_cnt >= SLOT_W), updated on the event.
REQ-022 SHALL load a 2*SLOT_W shift register on the event where bit_cnt becomes 0 (mode=1) or 1 (mode=0): {sample_l, zeros(SLOT_W-SAMPLE_W), sample_r, zeros(SLOT_W-SAMPLE_W)}.
REQ-023 SHALL pop the FIFO head on that load event; if empty, SHALL load all zeros and pulse underrun for exactly one clk.
REQ-024 SHALL shift out one bit per event, MSB first; sdata changes only on events, so it is stable across every bclk rising edge.
REQ-025 In mode 0, right-slot LSB SHALL appear at bit_cnt 0 of the following frame.
REQ-026 Push and pop in the same clk SHALL both take effect; fifo_level is unchanged when both occur.
REQ-027 Pop with FIFO empty and concurrent push SHALL report underrun; the pushed entry SHALL be retained.
REQ-028 Push while full SHALL be impossible because ready is low; ready SHALL rise the clk after a pop.
REQ-029 enable low SHALL, at the next clk, zero div_cnt, bit_cnt, shift register, bclk, lrclk and sdata; the FIFO keeps its contents and accepts pushes.
REQ-030 enable rising SHALL start at div_cnt=0, bit_cnt=0; the first load follows per REQ-022.
REQ-031 mode SHALL be sampled only at the bit_cnt=0 event; changes mid-frame take effect at the next frame.

Reset
REQ-032 Reset SHALL asynchronously clear div_cnt, bit_cnt, shift register, FIFO pointers and level to 0.
REQ-033 Reset SHALL asynchronously drive bclk, lrclk, sdata and underrun to 0; sample_ready reads 1.
REQ-034 Reset asserted mid-frame SHALL discard the in-flight frame and all FIFO contents.

Structure
REQ-035 Mode encodings (I2S_MODE_PHILIPS=0, I2S_MODE_LJ=1) SHALL live in shared header i2s_defs.vh, included by this block and the audio top.
REQ-036 Storage SHALL be a sub-module sample_fifo: synchronous FIFO, width 2*SAMPLE_W, depth FIFO_DEPTH, ports clk, reset, push, pop, din, dout, level.

Verification (SAMPLE_W=16, SLOT_W=16, BCLK_DIV=4, FIFO_DEPTH=4)
REQ-037 Push L=16'hA5F0, R=16'h0F0F, mode 0 -> sdata bits sampled on bclk rise at bit_cnt 1..16 give A5F0, bit_cnt 17..31,0 give 0F0F; lrclk toggles every 64 clk.
REQ-038 Same pair, mode 1 -> MSB at bit_cnt 0; lrclk edge coincides with MSB of each slot.
REQ-039 No pushes after reset -> sdata stays 0; underrun pulses once every 128 clk.
REQ-040 Push 5 pairs back-to-back with enable low -> ready drops after 4 accepted, fifo_level=4; the fifth is accepted the clk after the first pop.
REQ-041 SLOT_W=24, SAMPLE_W=16, L=16'h8001 -> 16 data bits then 8 zeros per slot; frame = 48 bclk.
REQ-042 Assert reset at bit_cnt=10 with 3 entries queued -> bclk, lrclk, sdata=0 and fifo_level=0 within the same cycle; output restarts cleanly after release.

Source files
------------

// File: rtl/i2s_tx_param_pkg.sv
// Types and helpers shared by the parameterised I2S transmitter.
`include "i2s_defs.vh"

package i2s_tx_param_pkg;

  typedef enum logic {
    MODE_PHILIPS = `I2S_MODE_PHILIPS,
    MODE_LJ      = `I2S_MODE_LJ
  } i2s_mode_e;

  // Left-justified loads with the frame's first bit, Philips one bit later.
  function automatic logic load_due(input i2s_mode_e m, input logic at_bit0, input logic at_bit1);
    logic due;
    case (m)
      MODE_LJ:      due = at_bit0;
      MODE_PHILIPS: due = at_bit1;
      default:      due = 1'b0;
    endcase
    return due;
  endfunction

endpackage

// File: rtl/i2s_defs.vh
// Word-format encodings shared by the I2S transmitter and the audio top.
`ifndef I2S_DEFS_VH
`define I2S_DEFS_VH
`define I2S_MODE_PHILIPS 1'b0
`define I2S_MODE_LJ      1'b1
`endif

// File: rtl/i2s_tx_param_sample_fifo.sv
// Synchronous FIFO of stereo sample pairs with registered occupancy.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_nxt_s;
  logic             push_s;
  logic             pop_s;

  assign push_s = push && (level_r != LVL_W'(DEPTH));
  assign pop_s  = pop && (level_r != '0);
  assign dout   = mem_r[rd_ptr_r];
  assign level  = level_r;

  // Occupancy after this cycle's accepted push and/or pop.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointers and level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r <= level_nxt_s;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/i2s_tx_param.sv
// Parameterised I2S / left-justified serial transmitter fed from a sample FIFO.
`include "i2s_defs.vh"

module i2s_tx_param
  import i2s_tx_param_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 16,
  parameter int BCLK_DIV   = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          mode,
  input  logic [SAMPLE_W-1:0]           sample_l,
  input  logic [SAMPLE_W-1:0]           sample_r,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int FRM_W = 2 * SLOT_W;
  localparam int BIT_W = $clog2(FRM_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRM_W - 1);

  logic [DIV_W-1:0]      div_cnt_r, div_nxt_s;
  logic [BIT_W-1:0]      bit_cnt_r, bit_nxt_s;
  logic [FRM_W-1:0]      shreg_r, frame_s;
  logic [2*SAMPLE_W-1:0] head_s;
  logic                  running_r, bclk_r, lrclk_r, sdata_r, underrun_r;
  i2s_mode_e             mode_r, load_mode_s;
  logic                  start_s, wrap_s, event_s, load_s, push_s, pop_s, empty_s;

  assign sample_ready = (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push_s       = sample_valid && sample_ready;
  assign empty_s      = (fifo_level == '0);
  assign pop_s        = load_s && !empty_s;
  assign bclk         = bclk_r;
  assign lrclk        = lrclk_r;
  assign sdata        = sdata_r;
  assign underrun     = underrun_r;

  sample_fifo #(
    .WIDTH (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({sample_l, sample_r}),
    .dout  (head_s),
    .level (fifo_level)
  );

  // Divider and bit counter; the first enabled cycle acts as the bit-0 event.
  always_comb begin
    div_nxt_s = '0;
    bit_nxt_s = '0;
    start_s   = 1'b0;
    wrap_s    = 1'b0;
    if (enable) begin
      if (!running_r) begin
        start_s = 1'b1;
      end else if (div_cnt_r == DIV_LAST) begin
        wrap_s = 1'b1;
        if (bit_cnt_r == BIT_LAST) begin
          bit_nxt_s = '0;
        end else begin
          bit_nxt_s = bit_cnt_r + BIT_W'(1);
        end
      end else begin
        div_nxt_s = div_cnt_r + DIV_W'(1);
        bit_nxt_s = bit_cnt_r;
      end
    end else begin
      div_nxt_s = '0;
    end
  end

  // Mode is taken fresh only at a frame start; mid-frame the latched copy rules.
  always_comb begin
    event_s     = start_s || wrap_s;
    load_mode_s = mode_r;
    if (event_s && (bit_nxt_s == '0)) begin
      load_mode_s = i2s_mode_e'(mode);
    end else begin
      load_mode_s = mode_r;
    end
    load_s  = event_s && load_due(load_mode_s, bit_nxt_s == '0, bit_nxt_s == BIT_W'(1));
    frame_s = '0;
    if (!empty_s) begin
      frame_s[FRM_W-1  -: SAMPLE_W] = head_s[2*SAMPLE_W-1 -: SAMPLE_W];
      frame_s[SLOT_W-1 -: SAMPLE_W] = head_s[SAMPLE_W-1:0];
    end else begin
      frame_s = '0;
    end
  end

  // Serial engine state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r  <= '0;
      bit_cnt_r  <= '0;
      shreg_r    <= '0;
      running_r  <= 1'b0;
      mode_r     <= MODE_PHILIPS;
      bclk_r     <= 1'b0;
      lrclk_r    <= 1'b0;
      sdata_r    <= 1'b0;
      underrun_r <= 1'b0;
    end else if (!enable) begin
      div_cnt_r  <= '0;
      bit_cnt_r  <= '0;
      shreg_r    <= '0;
      running_r  <= 1'b0;
      bclk_r     <= 1'b0;
      lrclk_r    <= 1'b0;
      sdata_r    <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      running_r  <= 1'b1;
      div_cnt_r  <= div_nxt_s;
      bit_cnt_r  <= bit_nxt_s;
      bclk_r     <= (div_nxt_s >= DIV_HALF);
      underrun_r <= load_s && empty_s;
      if (event_s) begin
        mode_r  <= load_mode_s;
        lrclk_r <= (bit_nxt_s >= BIT_W'(SLOT_W));
        if (load_s) begin
          sdata_r <= frame_s[FRM_W-1];
          shreg_r <= frame_s << 1;
        end else begin
          sdata_r <= shreg_r[FRM_W-1];
          shreg_r <= shreg_r << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_param.sv
// Scoreboard bench for i2s_tx_param: 16-bit slots plus a 24-bit-slot instance.
module tb_i2s_tx_param;

  localparam int SW    = 16;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, mode, sample_valid;
  logic [SW-1:0] sample_l, sample_r;
  logic          sample_ready, bclk, lrclk, sdata, underrun;
  logic [LW-1:0] fifo_level;

  logic          w_enable, w_mode, w_valid;
  logic [SW-1:0] w_l, w_r;
  logic          w_ready, w_bclk, w_lrclk, w_sdata, w_underrun;
  logic [LW-1:0] w_level;

  int checks = 0;
  int errors = 0;

  logic [2*SW-1:0] pair_q[$];
  logic [1:0]      exp_q[$];

  always #5 clk = ~clk;

  i2s_tx_param #(.SAMPLE_W(SW), .SLOT_W(16), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .underrun(underrun), .fifo_level(fifo_level));

  i2s_tx_param #(.SAMPLE_W(SW), .SLOT_W(24), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) u_dut_w (
    .clk(clk), .reset(reset), .enable(w_enable), .mode(w_mode),
    .sample_l(w_l), .sample_r(w_r), .sample_valid(w_valid),
    .sample_ready(w_ready), .bclk(w_bclk), .lrclk(w_lrclk), .sdata(w_sdata),
    .underrun(w_underrun), .fifo_level(w_level));

  function automatic logic cur_bclk(input int which);
    return (which == 1) ? w_bclk : bclk;
  endfunction

  function automatic logic [1:0] cur_ser(input int which);
    return (which == 1) ? {w_lrclk, w_sdata} : {lrclk, sdata};
  endfunction

  task automatic wait_bclk_rise(input int which, output bit ok);
    logic prev;
    prev = cur_bclk(which);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!prev && cur_bclk(which)) begin
        ok = 1'b1;
        break;
      end
      prev = cur_bclk(which);
    end
  endtask

  // Expected {lrclk, sdata} per bclk rise, counted from the enable rise.
  task automatic build_expected(input int slot, input logic md, input int nframes);
    int f;
    logic [63:0] fv;
    logic [2*SW-1:0] pr;
    f = 2 * slot;
    if (md == 1'b0) exp_q.push_back(2'b00);
    for (int n = 0; n < nframes; n++) begin
      if (pair_q.size() > 0) pr = pair_q.pop_front();
      else pr = '0;
      fv = '0;
      fv[f-1 -: SW]    = pr[2*SW-1:SW];
      fv[slot-1 -: SW] = pr[SW-1:0];
      for (int j = 0; j < f; j++) begin
        int k;
        logic lr_e;
        k = (md == 1'b0) ? ((j + 1) % f) : j;
        lr_e = (k >= slot);
        exp_q.push_back({lr_e, fv[f-1-j]});
      end
    end
  endtask

  task automatic check_stream(input int which, input string name);
    logic [1:0] exp_v, got_v;
    bit ok;
    int idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      wait_bclk_rise(which, ok);
      checks++;
      if (!ok) begin
        $display("FAIL %s bit %0d: got no bclk rise, expected a rise within 64 clk", name, idx);
        errors++;
        exp_q.delete();
      end else begin
        exp_v = exp_q.pop_front();
        got_v = cur_ser(which);
        if (got_v !== exp_v) begin
          $display("FAIL %s bit %0d: got lrclk,sdata=%b expected %b", name, idx, got_v, exp_v);
          errors++;
        end
        idx++;
      end
    end
  endtask

  task automatic check_idle(input int which, input string name);
    logic [2:0] got;
    if (which == 1) w_enable = 1'b0;
    else enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = {cur_bclk(which), cur_ser(which)};
    checks++;
    if (got !== 3'b000) begin
      $display("FAIL %s: got bclk,lrclk,sdata=%b expected 000", name, got);
      errors++;
    end
  endtask

  task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic rdy;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    rdy = sample_ready;
    @(negedge clk);
    sample_valid = 1'b0;
    checks++;
    if (rdy !== 1'b1) begin
      $display("FAIL push_ready: got %b expected 1", rdy);
      errors++;
    end else begin
      pair_q.push_back({l, r});
    end
  endtask

  task automatic test_reset;
    checks += 6;
    if (bclk !== 1'b0)       begin $display("FAIL rst_bclk: got %b expected 0", bclk); errors++; end
    if (lrclk !== 1'b0)      begin $display("FAIL rst_lrclk: got %b expected 0", lrclk); errors++; end
    if (sdata !== 1'b0)      begin $display("FAIL rst_sdata: got %b expected 0", sdata); errors++; end
    if (underrun !== 1'b0)   begin $display("FAIL rst_underrun: got %b expected 0", underrun); errors++; end
    if (fifo_level !== '0)   begin $display("FAIL rst_level: got %0d expected 0", fifo_level); errors++; end
    if (sample_ready !== 1'b1) begin $display("FAIL rst_ready: got %b expected 1", sample_ready); errors++; end
  endtask

  task automatic test_mode(input logic md, input string name);
    push_pair(16'hA5F0, 16'h0F0F);
    checks++;
    if (fifo_level !== LW'(1)) begin
      $display("FAIL %s_level: got %0d expected 1", name, fifo_level);
      errors++;
    end
    mode = md;
    enable = 1'b1;
    build_expected(16, md, 2);
    check_stream(0, name);
    check_idle(0, {name, "_idle"});
  endtask

  task automatic test_underrun;
    int pulses[$];
    bit sd_seen;
    sd_seen = 1'b0;
    mode = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) pulses.push_back(i);
      if (sdata !== 1'b0) sd_seen = 1'b1;
    end
    checks += 2;
    if (pulses.size() != 4) begin
      $display("FAIL underrun_count: got %0d expected 4", pulses.size());
      errors++;
    end
    if (sd_seen) begin
      $display("FAIL underrun_sdata: got 1 expected 0");
      errors++;
    end
    for (int p = 1; p < pulses.size(); p++) begin
      checks++;
      if (pulses[p] - pulses[p-1] != 128) begin
        $display("FAIL underrun_period: got %0d expected 128", pulses[p] - pulses[p-1]);
        errors++;
      end
    end
    check_idle(0, "underrun_idle");
  endtask

  task automatic test_back_to_back;
    logic [SW-1:0] pl [5];
    logic [SW-1:0] pr [5];
    logic rdy;
    int acc, guard;
    for (int i = 0; i < 5; i++) begin
      pl[i] = SW'($urandom);
      pr[i] = SW'($urandom);
    end
    mode = 1'b1;
    acc = 0;
    guard = 0;
    sample_valid = 1'b1;
    while (acc < 4 && guard < 20) begin
      sample_l = pl[acc];
      sample_r = pr[acc];
      rdy = sample_ready;
      @(negedge clk);
      if (rdy) begin
        pair_q.push_back({pl[acc], pr[acc]});
        acc++;
      end
      guard++;
    end
    sample_l = pl[4];
    sample_r = pr[4];
    for (int c = 0; c < 2; c++) begin
      checks += 2;
      if (fifo_level !== LW'(4)) begin $display("FAIL b2b_full_level: got %0d expected 4", fifo_level); errors++; end
      if (sample_ready !== 1'b0) begin $display("FAIL b2b_full_ready: got %b expected 0", sample_ready); errors++; end
      @(negedge clk);
    end
    enable = 1'b1;
    @(negedge clk);
    checks += 2;
    if (sample_ready !== 1'b1) begin $display("FAIL b2b_ready_rise: got %b expected 1", sample_ready); errors++; end
    if (fifo_level !== LW'(3)) begin $display("FAIL b2b_after_pop: got %0d expected 3", fifo_level); errors++; end
    @(negedge clk);
    sample_valid = 1'b0;
    pair_q.push_back({pl[4], pr[4]});
    checks++;
    if (fifo_level !== LW'(4)) begin $display("FAIL b2b_fifth: got %0d expected 4", fifo_level); errors++; end
    build_expected(16, 1'b1, 6);
    check_stream(0, "b2b_stream");
    check_idle(0, "b2b_idle");
  endtask

  task automatic test_reset_mid;
    bit ok;
    for (int i = 0; i < 4; i++) push_pair(16'hFFFF, 16'hFFFF);
    mode = 1'b1;
    enable = 1'b1;
    for (int i = 0; i <= 10; i++) wait_bclk_rise(0, ok);
    checks += 2;
    if (sdata !== 1'b1) begin $display("FAIL mid_pre_sdata: got %b expected 1", sdata); errors++; end
    if (fifo_level !== LW'(3)) begin $display("FAIL mid_pre_level: got %0d expected 3", fifo_level); errors++; end
    reset = 1'b1;
    #1;
    checks += 5;
    if (bclk !== 1'b0)  begin $display("FAIL mid_bclk: got %b expected 0", bclk); errors++; end
    if (lrclk !== 1'b0) begin $display("FAIL mid_lrclk: got %b expected 0", lrclk); errors++; end
    if (sdata !== 1'b0) begin $display("FAIL mid_sdata: got %b expected 0", sdata); errors++; end
    if (fifo_level !== '0) begin $display("FAIL mid_level: got %0d expected 0", fifo_level); errors++; end
    if (sample_ready !== 1'b1) begin $display("FAIL mid_ready: got %b expected 1", sample_ready); errors++; end
    pair_q.delete();
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_pair(16'h1234, 16'hFEDC);
    mode = 1'b0;
    enable = 1'b1;
    build_expected(16, 1'b0, 2);
    check_stream(0, "mid_restart");
    check_idle(0, "mid_idle");
  endtask

  task automatic test_slot24;
    w_l = 16'h8001;
    w_r = 16'h00FF;
    w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    pair_q.push_back({w_l, w_r});
    checks++;
    if (w_level !== LW'(1)) begin $display("FAIL slot24_level: got %0d expected 1", w_level); errors++; end
    w_mode = 1'b1;
    w_enable = 1'b1;
    build_expected(24, 1'b1, 2);
    check_stream(1, "slot24");
    check_idle(1, "slot24_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0; mode = 1'b0; sample_valid = 1'b0;
    sample_l = '0; sample_r = '0;
    w_enable = 1'b0; w_mode = 1'b0; w_valid = 1'b0; w_l = '0; w_r = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_mode(1'b0, "mode0");
    test_mode(1'b1, "mode1");
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    test_slot24();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
